bcd_display_driver: RTL and testbench
=====================================

# bcd_display_driver

Downstream consumer of the summation FSMD's 8-bit `out` result. It converts the binary value to three BCD digits with a multi-cycle shift-and-add-3 (double-dabble) FSMD. It then drives a time-multiplexed three-digit 7-segment display. Conversion restarts automatically whenever the input differs from the last converted value, because the producer has no valid strobe.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays enabled; legal range 2..2^20.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  reset, asynchronous, active-low.
- `din`  input  8  unsigned binary value to display, 0..255.
- `bcd`  output  12  last converted value: [11:8] hundreds, [7:4] tens, [3:0] ones.
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  one-cycle pulse when `bcd` has just been updated.
- `seg`  output  7  segment drive, active-high, {g,f,e,d,c,b,a}.
- `an`  output  3  digit enable, one-hot, active-high: 001 ones, 010 tens, 100 hundreds.

## Operation
- Reset values:
  - `bcd`=0, `last`=0, `busy`=0, `done`=0.
  - Scan counter=0, digit index=0 (ones).
  - Therefore `an`=001 and `seg`=0111111 (digit "0").
- Conversion FSM states: IDLE, ADJ, SHIFT, DONE.
- IDLE:
  - If `din` != `last`: load `work` = {12'b0, din}, `cnt`=0, go to ADJ.
  - Otherwise stay in IDLE.
- ADJ: each of the three BCD nibbles `work[19:8]` that is >= 5 gets +3 (4-bit add, never overflows). Go to SHIFT.
- SHIFT:
  - `work` <= `work` << 1, `cnt` <= `cnt`+1.
  - If the new `cnt` = 8, go to DONE; otherwise go back to ADJ.
- DONE:
  - `bcd` <= `work[19:8]`.
  - `last` <= the value captured at load.
  - `done` <= 1.
  - Go to IDLE.
- `done` is registered and clears on the next edge.
- `busy` = (state != IDLE), decoded from the state register.
- `din` is ignored while busy. A change during a conversion is picked up on the first IDLE cycle afterwards.
- An unused state encoding returns to IDLE with `busy`=0.
- Scan logic:
  - Free-running counter runs 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0→1→2→0.
  - `an` and `seg` are registered from the index and `bcd`.
- Leading-zero blanking (`seg`=0000000, `an` still asserted):
  - Hundreds digit blanks when it is 0.
  - Tens digit blanks when hundreds = 0 and tens = 0.
  - Ones digit is never blanked.
- Segment codes (gfedcba):
  - 0: 0111111, 1: 0000110, 2: 1011011, 3: 1001111, 4: 1100110
  - 5: 1101101, 6: 1111101, 7: 0000111, 8: 1111111, 9: 1101111
  - Nibble codes 10..15 cannot occur; map them to blank.

## Timing
- Capture edge E0 (IDLE with `din` != `last`).
- E1..E16 alternate ADJ and SHIFT: 8 ADJ and 8 SHIFT cycles.
- E17 executes DONE: `bcd` is updated and `done` is high during the cycle after E17.
- Total latency: 18 rising edges from capture to updated `bcd`, including E0.
- `busy` is high from after E0 until E17.
- Back-to-back conversions: the earliest next capture is E18.
- Scan and conversion run independently. Updated `bcd` is reflected in `seg` on the next scan register update (one cycle later).
- Reset mid-conversion clears immediately:
  - FSM goes to IDLE; `busy` and `done` go to 0.
  - `bcd` and `last` go to 0; scan counter and index go to 0.
  - After release, a nonzero `din` triggers a fresh conversion.
- `din`=0 after reset triggers no conversion; `bcd`=0 is already correct.

## Test plan
- **Reset:** reset low, then release with `din`=0 → `bcd`=0x000, `busy`=0, `done` never pulses, `an`=001, `seg`=0111111.
- **Summation result:** `din` 0→55 (as the summation block's output settles) → `busy` for 17 cycles, `done` pulses once at edge 18, `bcd`=0x055. With SCAN_DIV=4, the hundreds slot is blank, tens shows 1101101, ones shows 1101101.
- **Boundary values:** 255 → 0x255; then 100 → 0x100 (tens shows "0", not blanked); then 9 → 0x009; then 0 → 0x000. Each takes exactly 18 edges.
- **Input change mid-conversion:** `din`=37, then `din`=200 at E5 → first `done` gives `bcd`=0x037; second conversion starts on the first IDLE cycle and gives `bcd`=0x200; 2 `done` pulses in total.
- **Reset mid-conversion:** `din`=123, assert reset at E9 → all outputs return to reset values asynchronously. After release, `bcd`=0x123 18 edges after the capture.
- **Scan cadence:** SCAN_DIV=4, `bcd`=0x255 → `an` sequence 001, 010, 100, 001, each held 4 cycles, with `seg` matching 5, 5, 2, 5.

Source files
------------

// File: rtl/bcd_display_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a three-digit
// time-multiplexed 7-segment display with leading-zero blanking.
module bcd_display_driver #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  din,
    output logic [11:0] bcd,
    output logic        busy,
    output logic        done,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADJ   = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3
    } state_t;

    localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

    state_t      state_reg;
    logic [19:0] work_reg;
    logic [3:0]  cnt_reg;
    logic [7:0]  cap_reg;
    logic [7:0]  last_reg;
    logic [11:0] bcd_reg;
    logic        done_reg;

    logic [19:0] scan_cnt_reg;
    logic [1:0]  digit_idx_reg;
    logic [2:0]  an_reg;
    logic [6:0]  seg_reg;

    logic [11:0] adj_digits;
    logic [6:0]  digit_seg [3];
    logic [2:0]  digit_blank;
    logic [2:0]  an_next;
    logic [6:0]  seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            // Add-3 correction so the following shift carries correctly into the next decade.
            assign adj_digits[gi*4 +: 4] = (work_reg[8 + gi*4 +: 4] >= 4'd5)
                                         ? work_reg[8 + gi*4 +: 4] + 4'd3
                                         : work_reg[8 + gi*4 +: 4];
            assign digit_seg[gi] = seg_decode(bcd_reg[gi*4 +: 4]);
        end
    endgenerate

    assign digit_blank[0] = 1'b0;
    assign digit_blank[1] = (bcd_reg[11:8] == 4'd0) && (bcd_reg[7:4] == 4'd0);
    assign digit_blank[2] = (bcd_reg[11:8] == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            cnt_reg   <= '0;
            cap_reg   <= '0;
            last_reg  <= '0;
            bcd_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (din != last_reg) begin
                        work_reg  <= {12'b0, din};
                        cap_reg   <= din;
                        cnt_reg   <= '0;
                        state_reg <= ADJ;
                    end
                end
                ADJ: begin
                    work_reg[19:8] <= adj_digits;
                    state_reg      <= SHIFT;
                end
                SHIFT: begin
                    work_reg  <= work_reg << 1;
                    cnt_reg   <= cnt_reg + 4'd1;
                    state_reg <= (cnt_reg == 4'd7) ? DONE : ADJ;
                end
                DONE: begin
                    bcd_reg   <= work_reg[19:8];
                    last_reg  <= cap_reg;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        an_next  = 3'b001;
        seg_next = digit_blank[0] ? 7'b0000000 : digit_seg[0];
        case (digit_idx_reg)
            2'd1: begin
                an_next  = 3'b010;
                seg_next = digit_blank[1] ? 7'b0000000 : digit_seg[1];
            end
            2'd2: begin
                an_next  = 3'b100;
                seg_next = digit_blank[2] ? 7'b0000000 : digit_seg[2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= '0;
            an_reg        <= 3'b001;
            seg_reg       <= 7'b0111111;
        end else begin
            if (scan_cnt_reg == SCAN_LAST) begin
                scan_cnt_reg  <= '0;
                digit_idx_reg <= (digit_idx_reg == 2'd2) ? 2'd0 : digit_idx_reg + 2'd1;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + 20'd1;
            end
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign bcd  = bcd_reg;
    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign seg  = seg_reg;
    assign an   = an_reg;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboarded bench for bcd_display_driver: conversions are checked on each
// done pulse (value and edge timing), display scanning is checked directly.
module tb_bcd_display_driver;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  din = 8'd0;
    logic [11:0] bcd;
    logic        busy;
    logic        done;
    logic [6:0]  seg;
    logic [2:0]  an;

    bcd_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [11:0] bcd;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int done_seen = 0;
    int busy_run = 0;

    // Monitor: pops one expectation per done pulse, and checks busy run length.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            busy_run = 0;
        end else begin
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                tests++;
                if (busy_run != 17) begin
                    fails++;
                    $display("FAIL busy_len: got %0d cycles, want 17", busy_run);
                end
                busy_run = 0;
            end
            if (done) begin
                done_seen++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: bcd=%03h at cycle %0d, want no pulse", bcd, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bcd !== e.bcd || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL convert: bcd=%03h at cycle %0d, want bcd=%03h at cycle %0d",
                                 bcd, cyc, e.bcd, e.cyc);
                    end else begin
                        $display("[TB] done bcd=%03h at cycle %0d ok", bcd, cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic drive(input logic [7:0] v, input logic [11:0] b);
        exp_t e;
        @(negedge clk);
        din = v;
        e.bcd = b;
        e.cyc = cyc + 18;
        exp_q.push_back(e);
        $display("[TB] drive din=%0d expect bcd=%03h", v, b);
    endtask

    task automatic wait_idle();
        bool_loop: begin
            for (int i = 0; i < 200; i++) begin
                if (exp_q.size() == 0 && !busy) disable bool_loop;
                @(negedge clk);
            end
            tests++;
            fails++;
            $display("FAIL wait_idle: timeout with %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_display(input logic [6:0] h_seg, input logic [6:0] t_seg, input logic [6:0] o_seg);
        logic [2:0] prev;
        logic [2:0] want_an;
        logic [6:0] want_seg;
        bit found;
        found = 1'b0;
        prev = an;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (prev == 3'b100 && an == 3'b001) begin
                found = 1'b1;
                break;
            end
            prev = an;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL scan_align: an=%03b never wrapped 100->001", an);
        end else begin
            for (int i = 0; i <= 12; i++) begin
                if (i > 0) @(negedge clk);
                case ((i / 4) % 3)
                    0: begin want_an = 3'b001; want_seg = o_seg; end
                    1: begin want_an = 3'b010; want_seg = t_seg; end
                    default: begin want_an = 3'b100; want_seg = h_seg; end
                endcase
                check("scan_an", {29'd0, an}, {29'd0, want_an});
                check("scan_seg", {25'd0, seg}, {25'd0, want_seg});
            end
            $display("[TB] display h=%07b t=%07b o=%07b checked", h_seg, t_seg, o_seg);
        end
    endtask

    initial begin
        exp_t e;
        // Reset with din=0
        repeat (3) @(negedge clk);
        check("rst_bcd", {20'd0, bcd}, 32'h000);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_an", {29'd0, an}, 32'b001);
        check("rst_seg", {25'd0, seg}, 32'b0111111);
        reset = 1'b1;
        #1;
        check("rel_an", {29'd0, an}, 32'b001);
        check("rel_seg", {25'd0, seg}, 32'b0111111);
        repeat (25) @(negedge clk);
        check("idle_bcd", {20'd0, bcd}, 32'h000);
        check("idle_busy", {31'd0, busy}, 32'd0);
        $display("[TB] reset with din=0 checked");

        drive(8'd55, 12'h055);
        wait_idle();
        check_display(7'b0000000, 7'b1101101, 7'b1101101);

        drive(8'd255, 12'h255);
        wait_idle();
        check_display(7'b1011011, 7'b1101101, 7'b1101101);

        drive(8'd100, 12'h100);
        wait_idle();
        check_display(7'b0000110, 7'b0111111, 7'b0111111);

        drive(8'd9, 12'h009);
        wait_idle();
        check_display(7'b0000000, 7'b0000000, 7'b1101111);

        drive(8'd0, 12'h000);
        wait_idle();
        check_display(7'b0000000, 7'b0000000, 7'b0111111);

        // Input change mid-conversion: second capture lands on E18
        drive(8'd37, 12'h037);
        repeat (5) @(negedge clk);
        din = 8'd200;
        e.bcd = 12'h200;
        e.cyc = cyc + 31;
        exp_q.push_back(e);
        $display("[TB] drive din=200 mid-conversion expect bcd=200");
        wait_idle();
        check_display(7'b1011011, 7'b0111111, 7'b0111111);

        // Reset mid-conversion
        @(negedge clk);
        din = 8'd123;
        repeat (9) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_bcd", {20'd0, bcd}, 32'h000);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_an", {29'd0, an}, 32'b001);
        check("midrst_seg", {25'd0, seg}, 32'b0111111);
        $display("[TB] reset mid-conversion checked");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        e.bcd = 12'h123;
        e.cyc = cyc + 18;
        exp_q.push_back(e);
        wait_idle();
        check_display(7'b0000110, 7'b1011011, 7'b1001111);

        // Scan cadence on 255
        drive(8'd255, 12'h255);
        wait_idle();
        check_display(7'b1011011, 7'b1101101, 7'b1101101);

        check("done_count", done_seen, 32'd9);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
